// File: rtl/cdc_hs_pkg.sv
`timescale 1ns/1ps
// Shared types for the source side of the req/ack CDC handshake.
package cdc_hs_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } cdc_hs_state_t;

  localparam int XFER_CNT_W = 16;
endpackage

// File: rtl/cdc_sync2.sv
`timescale 1ns/1ps
// Two-flop level synchronizer; output follows input after two destination edges.
// Reset clears both stages so a freshly reset block never sees a stale level.
module cdc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/cdc_handshake_tx.sv
`timescale 1ns/1ps
// Source end of a 4-phase req/ack crossing: word is held on x_data from accept until
// the return-to-zero phase completes; s_ready stays low for the whole transfer.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  x_req,
  output logic [WIDTH-1:0]      x_data,
  input  logic                  x_ack,
  output logic                  done,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  timeout
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  cdc_hs_state_t          state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic [XFER_CNT_W-1:0]  xfer_q, xfer_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;
  logic                   ack_s;
  logic                   rst_n;
  logic                   busy;

  assign rst_n = ~rst;

  cdc_sync2 #(.WIDTH(1)) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (x_ack),
    .q    (ack_s)
  );

  // A lingering ack in IDLE blocks new words so a stuck receiver cannot skip a phase.
  assign s_ready = (state_q == IDLE) && !ack_s;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    xfer_d  = xfer_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    if (busy && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    if (busy && (TIMEOUT != 0) && (cnt_q == CNT_MAX)) tmo_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          data_d  = s_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          xfer_d  = xfer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      xfer_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      xfer_q  <= xfer_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign x_req      = req_q;
  assign x_data     = data_q;
  assign done       = done_q;
  assign xfer_count = xfer_q;
  assign timeout    = tmo_q;
endmodule
